fifo_uart_tx: RTL and testbench

Serial transmitter that drains the read port of the synchronizer FIFO and emits each byte as an asynchronous UART frame on a single line. It sits in the read-clock domain, directly downstream of the FIFO. It issues single-cycle read requests, captures the returned word on the FIFO's valid strobe, and serializes it as start bit, data LSB first, optional parity, and stop bit.

---
 rtl/fifo_uart_tx.sv | 166 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter draining a FIFO read port: one single-cycle read request per
// frame, word captured on the valid strobe, sent as start/data LSB-first/parity/stop.
module fifo_uart_tx #(
  parameter int DATA_WIDTH   = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic                  CLK,
  input  logic                  rst,
  input  logic                  Empty,
  input  logic                  TX_D_Valid,
  input  logic [DATA_WIDTH-1:0] D_IN,
  input  logic                  Par_En,
  input  logic                  Par_Typ,
  output logic                  Rd_Req,
  output logic                  TX_OUT,
  output logic                  Busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_START  = 3'd2;
  localparam logic [2:0] S_DATA   = 3'd3;
  localparam logic [2:0] S_PARITY = 3'd4;
  localparam logic [2:0] S_STOP   = 3'd5;

  logic [2:0]            state_q, state_d;
  logic [CW-1:0]         baud_q, baud_d;
  logic [IW-1:0]         idx_q, idx_d, idx_inc;
  logic [1:0]            fetch_q, fetch_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  par_en_q, par_en_d;
  logic                  parity_q, parity_d;
  logic                  rd_q, rd_d;
  logic                  tx_q, tx_d;
  logic                  busy_q, busy_d;
  logic                  baud_done;

  assign baud_done = (baud_q == CW'(CLKS_PER_BIT - 1));
  assign idx_inc   = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    baud_d   = baud_q;
    idx_d    = idx_q;
    fetch_d  = fetch_q;
    data_d   = data_q;
    par_en_d = par_en_q;
    parity_d = parity_q;
    tx_d     = tx_q;
    rd_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        baud_d  = '0;
        idx_d   = '0;
        fetch_d = '0;
        tx_d    = 1'b1;
        if (!Empty) begin
          rd_d    = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        // A valid strobe on the third FETCH edge still wins over the give-up.
        if (TX_D_Valid) begin
          data_d   = D_IN;
          par_en_d = Par_En;
          parity_d = Par_Typ ? ~^D_IN : ^D_IN;
          tx_d     = 1'b0;
          baud_d   = '0;
          state_d  = S_START;
        end else if (fetch_q == 2'd2) begin
          state_d = S_IDLE;
        end else begin
          fetch_d = fetch_q + 1'b1;
        end
      end
      S_START: begin
        if (baud_done) begin
          baud_d  = '0;
          idx_d   = '0;
          tx_d    = data_q[0];
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_DATA: begin
        if (baud_done) begin
          baud_d = '0;
          if (idx_q == IW'(DATA_WIDTH - 1)) begin
            idx_d = '0;
            if (par_en_q) begin
              tx_d    = parity_q;
              state_d = S_PARITY;
            end else begin
              tx_d    = 1'b1;
              state_d = S_STOP;
            end
          end else begin
            idx_d = idx_inc;
            tx_d  = data_q[idx_inc];
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_PARITY: begin
        if (baud_done) begin
          baud_d  = '0;
          tx_d    = 1'b1;
          state_d = S_STOP;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      S_STOP: begin
        tx_d = 1'b1;
        if (baud_done) begin
          baud_d  = '0;
          state_d = S_IDLE;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q  <= S_IDLE;
      baud_q   <= '0;
      idx_q    <= '0;
      fetch_q  <= '0;
      data_q   <= '0;
      par_en_q <= 1'b0;
      parity_q <= 1'b0;
      rd_q     <= 1'b0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      baud_q   <= baud_d;
      idx_q    <= idx_d;
      fetch_q  <= fetch_d;
      data_q   <= data_d;
      par_en_q <= par_en_d;
      parity_q <= parity_d;
      rd_q     <= rd_d;
      tx_q     <= tx_d;
      busy_q   <= busy_d;
    end
  end

  assign Rd_Req = rd_q;
  assign TX_OUT = tx_q;
  assign Busy   = busy_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed + randomized bench for fifo_uart_tx; a queue-based FIFO model feeds the
// DUT and each frame is compared bit by bit against one built from the word's value.
module tb_fifo_uart_tx;

  localparam int DW  = 8;
  localparam int CPB = 4;

  logic          CLK = 1'b0;
  logic          rst;
  logic          Empty;
  logic          TX_D_Valid;
  logic [DW-1:0] D_IN;
  logic          Par_En;
  logic          Par_Typ;
  logic          Rd_Req;
  logic          TX_OUT;
  logic          Busy;

  fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB)) dut (
    .CLK(CLK), .rst(rst), .Empty(Empty), .TX_D_Valid(TX_D_Valid), .D_IN(D_IN),
    .Par_En(Par_En), .Par_Typ(Par_Typ), .Rd_Req(Rd_Req), .TX_OUT(TX_OUT), .Busy(Busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [DW-1:0] d;
    logic          pe;
    logic          pt;
  } word_t;

  word_t fifo[$];
  int    passed = 0;
  int    total  = 0;
  int    rd_count = 0;
  int    rd_long  = 0;
  logic  prev_rd  = 1'b0;
  logic  rd_pend  = 1'b0;
  logic  refuse   = 1'b0;
  logic  noise    = 1'b0;

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One cycle: wait for the falling edge, answer any pending read, drive next inputs.
  task automatic step();
    word_t w;
    @(negedge CLK);
    TX_D_Valid = 1'b0;
    D_IN       = DW'($urandom);
    Par_En     = 1'($urandom);
    Par_Typ    = 1'($urandom);
    if (rd_pend) begin
      if (fifo.size() > 0 && !refuse) begin
        w          = fifo.pop_front();
        TX_D_Valid = 1'b1;
        D_IN       = w.d;
        Par_En     = w.pe;
        Par_Typ    = w.pt;
      end
      rd_pend = 1'b0;
    end else if (noise) begin
      TX_D_Valid = 1'($urandom);
    end
    if (Rd_Req === 1'b1) begin
      rd_pend = 1'b1;
      rd_count++;
      if (prev_rd) rd_long++;
    end
    prev_rd = (Rd_Req === 1'b1);
    Empty = (fifo.size() == 0);
  endtask

  task automatic push(input logic [DW-1:0] d, input logic pe, input logic pt);
    word_t w;
    w.d = d; w.pe = pe; w.pt = pt;
    fifo.push_back(w);
    Empty = 1'b0;
  endtask

  task automatic wait_fall(output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (TX_OUT !== 1'b0 && n < 30);
  endtask

  // exp_wait > 0 also checks how many cycles elapse until the start bit is seen.
  task automatic check_frame(input logic [DW-1:0] d, input logic pe, input logic pt,
                             input int exp_wait, input string tag);
    int   n;
    logic bits[$];
    logic ok;
    int   ones;
    wait_fall(n);
    chk(TX_OUT, 1'b0, {tag, "_start_fall"});
    if (exp_wait > 0) chk(n, exp_wait, {tag, "_start_delay"});
    ones = $countones(d);
    bits.push_back(1'b0);
    for (int i = 0; i < DW; i++) bits.push_back(d[i]);
    if (pe) bits.push_back(pt ? (ones % 2 == 0) : (ones % 2 == 1));
    bits.push_back(1'b1);
    noise = 1'b1;
    for (int k = 0; k < bits.size(); k++) begin
      ok = 1'b1;
      for (int c = 0; c < CPB; c++) begin
        if (!(k == 0 && c == 0)) step();
        if (TX_OUT !== bits[k] || Busy !== 1'b1) ok = 1'b0;
      end
      chk(ok, 1'b1, $sformatf("%s_bit%0d_tx%0b", tag, k, bits[k]));
    end
    noise = 1'b0;
    step();
    chk(Busy, 1'b0, {tag, "_idle_busy"});
    chk(TX_OUT, 1'b1, {tag, "_idle_tx"});
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int            base;
    int            n;
    logic [5:0]    rd_v, bz_v;
    logic          tx_ok;
    word_t         rw[6];

    rst = 1'b1; Empty = 1'b1; TX_D_Valid = 1'b0; D_IN = '0; Par_En = 1'b0; Par_Typ = 1'b0;

    // Reset held with a pending word and a toggling valid strobe.
    push(8'hA5, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge CLK);
      TX_D_Valid = ~TX_D_Valid;
      chk({Rd_Req, TX_OUT, Busy}, 3'b010, $sformatf("reset_outputs_%0d", i));
    end
    TX_D_Valid = 1'b0;
    rst = 1'b0;
    base = rd_count;
    step();
    chk(Rd_Req, 1'b1, "first_rdreq_after_reset");
    check_frame(8'hA5, 1'b0, 1'b0, 2, "single_A5");
    for (int i = 0; i < 4; i++) step();
    chk(rd_count - base, 1, "single_A5_rd_pulses");
    chk(Busy, 1'b0, "single_A5_busy_after");

    push(8'h07, 1'b1, 1'b0);
    check_frame(8'h07, 1'b1, 1'b0, 3, "par_even_07");
    step();
    push(8'h07, 1'b1, 1'b1);
    check_frame(8'h07, 1'b1, 1'b1, 3, "par_odd_07");
    step();

    base = rd_count;
    push(8'h00, 1'b0, 1'b0);
    push(8'hFF, 1'b0, 1'b0);
    check_frame(8'h00, 1'b0, 1'b0, 3, "b2b_00");
    check_frame(8'hFF, 1'b0, 1'b0, 3, "b2b_FF");
    for (int i = 0; i < 4; i++) step();
    chk(rd_count - base, 2, "b2b_rd_pulses");

    // FIFO refuses the read: one request, give-up after three FETCH edges, retry.
    refuse = 1'b1;
    push(8'h81, 1'b0, 1'b0);
    tx_ok = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      rd_v[i] = Rd_Req;
      bz_v[i] = Busy;
      if (TX_OUT !== 1'b1) tx_ok = 1'b0;
    end
    chk(rd_v, 6'b010001, "refused_rdreq_pattern");
    chk(bz_v, 6'b110111, "refused_busy_pattern");
    chk(tx_ok, 1'b1, "refused_tx_high");
    refuse = 1'b0;
    check_frame(8'h81, 1'b0, 1'b0, 0, "after_refused_81");

    // Reset in the middle of data bit 3.
    push(8'h3C, 1'b1, 1'b0);
    wait_fall(n);
    chk(TX_OUT, 1'b0, "midrst_start_fall");
    for (int i = 0; i < (CPB - 1) + 3 * CPB + 1; i++) step();
    chk(TX_OUT, 1'b1, "midrst_bit3_value");
    rst = 1'b1;
    step();
    chk({TX_OUT, Busy, Rd_Req}, 3'b100, "midrst_outputs");
    step();
    rst = 1'b0;
    rd_pend = 1'b0;
    push(8'h5A, 1'b1, 1'b1);
    check_frame(8'h5A, 1'b1, 1'b1, 3, "after_midrst_5A");
    step();

    // Randomized back-to-back burst.
    for (int i = 0; i < 6; i++) begin
      rw[i].d  = DW'($urandom);
      rw[i].pe = 1'($urandom);
      rw[i].pt = 1'($urandom_range(0, 1));
      push(rw[i].d, rw[i].pe, rw[i].pt);
    end
    for (int i = 0; i < 6; i++)
      check_frame(rw[i].d, rw[i].pe, rw[i].pt, 3, $sformatf("rand%0d_%02h", i, rw[i].d));

    for (int i = 0; i < 5; i++) step();
    chk(Busy, 1'b0, "final_idle_busy");
    chk(rd_long, 0, "rdreq_single_cycle");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
